axi_lite_reg_slave: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 31 +++
 rtl/axi_lite_if.sv | 38 +++
 rtl/axi_lite_regbank.sv | 53 +++++
 rtl/axi_lite_reg_slave.sv | 142 ++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// axi_lite_pkg : shared AXI4-Lite widths, response codes and FSM state types
// Revision     : 1.0
// ============================================================================
package axi_lite_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = 5;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_DATA = 2'd2,
      W_RESP = 2'd3
   } wr_state_t;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_if.sv
`default_nettype none
// ============================================================================
// axi_lite : AXI4-Lite bundle with master and slave views
// Revision : 1.0
// ============================================================================
interface axi_lite #(
   parameter int AW = axi_lite_pkg::ADDR_W,
   parameter int DW = axi_lite_pkg::DATA_W
);
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;
   logic [AW-1:0]   araddr;
   logic            arvalid;
   logic            arready;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_regbank.sv
`default_nettype none
// ============================================================================
// axi_lite_regbank : byte-strobed register storage, one write port and a
//                    combinational read port
// Revision         : 1.0
// ============================================================================
module axi_lite_regbank
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [IDX_W-1:0]           wr_idx,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic [STRB_W-1:0]          wr_strb,
   input  logic [IDX_W-1:0]           rd_idx,
   output logic [DATA_W-1:0]          rd_data,
   output logic [NUM_REGS*DATA_W-1:0] q
);

   generate
      for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
         logic [DATA_W-1:0] r_word;
         logic              w_sel;

         assign w_sel = wr_en && (wr_idx == IDX_W'(k));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_word <= '0;
            end else if (w_sel) begin
               for (int b = 0; b < STRB_W; b++) begin
                  if (wr_strb[b]) r_word[8*b +: 8] <= wr_data[8*b +: 8];
               end
            end
         end

         assign q[k*DATA_W +: DATA_W] = r_word;
      end
   endgenerate

   // Unmatched indices read as zero; the top never forwards them anyway.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (rd_idx == IDX_W'(k)) rd_data = q[k*DATA_W +: DATA_W];
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// axi_lite_reg_slave : AXI4-Lite responder exposing NUM_REGS x 32-bit registers
// Revision           : 1.0
// ============================================================================
module axi_lite_reg_slave
   import axi_lite_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   axi_lite.slave                     s_axi,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic                       wr_pulse,
   output logic [IDX_W-1:0]           wr_idx
);

   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return int'(idx) < NUM_REGS;
   endfunction

   wr_state_t          r_wr_state, w_wr_next;
   rd_state_t          r_rd_state, w_rd_next;
   logic               r_awready, r_wready, r_arready;
   logic [IDX_W-1:0]   r_aw_idx;
   logic [DATA_W-1:0]  r_wdata;
   logic [STRB_W-1:0]  r_wstrb;
   resp_t              r_bresp, r_rresp;
   logic [DATA_W-1:0]  r_rdata;

   logic               w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic               w_commit, w_cmt_in_range, w_ar_in_range;
   logic [IDX_W-1:0]   w_cmt_idx, w_ar_idx;
   logic [DATA_W-1:0]  w_cmt_data, w_bank_rd;
   logic [STRB_W-1:0]  w_cmt_strb;
   logic               w_unused_addr_lsbs;

   assign w_unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   assign w_aw_hs = s_axi.awvalid & r_awready;
   assign w_w_hs  = s_axi.wvalid  & r_wready;
   assign w_b_hs  = (r_wr_state == W_RESP) & s_axi.bready;
   assign w_ar_hs = s_axi.arvalid & r_arready;
   assign w_r_hs  = (r_rd_state == R_DATA) & s_axi.rready;

   always_comb begin
      w_wr_next = r_wr_state;
      case (r_wr_state)
         W_IDLE: begin
            if (w_aw_hs && w_w_hs) w_wr_next = W_RESP;
            else if (w_w_hs)       w_wr_next = W_ADDR;
            else if (w_aw_hs)      w_wr_next = W_DATA;
         end
         W_DATA:  if (w_w_hs)  w_wr_next = W_RESP;
         W_ADDR:  if (w_aw_hs) w_wr_next = W_RESP;
         W_RESP:  if (w_b_hs)  w_wr_next = W_IDLE;
         default: w_wr_next = W_IDLE;
      endcase
   end

   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (w_ar_hs) w_rd_next = R_DATA;
         R_DATA:  if (w_r_hs)  w_rd_next = R_IDLE;
         default: w_rd_next = R_IDLE;
      endcase
   end

   // Whichever half arrives last is taken live; the earlier half comes from its latch.
   assign w_commit       = (r_wr_state != W_RESP) && (w_wr_next == W_RESP);
   assign w_cmt_idx      = w_aw_hs ? s_axi.awaddr[6:2] : r_aw_idx;
   assign w_cmt_data     = w_w_hs  ? s_axi.wdata       : r_wdata;
   assign w_cmt_strb     = w_w_hs  ? s_axi.wstrb       : r_wstrb;
   assign w_cmt_in_range = idx_in_range(w_cmt_idx);

   assign w_ar_idx       = s_axi.araddr[6:2];
   assign w_ar_in_range  = idx_in_range(w_ar_idx);

   axi_lite_regbank #(
      .NUM_REGS (NUM_REGS)
   ) u_regbank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_commit & w_cmt_in_range),
      .wr_idx  (w_cmt_idx),
      .wr_data (w_cmt_data),
      .wr_strb (w_cmt_strb),
      .rd_idx  (w_ar_idx),
      .rd_data (w_bank_rd),
      .q       (reg_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_state <= W_IDLE;
         r_rd_state <= R_IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_arready  <= 1'b0;
         r_aw_idx   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bresp    <= OKAY;
         r_rresp    <= OKAY;
         r_rdata    <= '0;
         wr_pulse   <= 1'b0;
         wr_idx     <= '0;
      end else begin
         r_wr_state <= w_wr_next;
         r_rd_state <= w_rd_next;
         r_awready  <= (w_wr_next == W_IDLE) || (w_wr_next == W_ADDR);
         r_wready   <= (w_wr_next == W_IDLE) || (w_wr_next == W_DATA);
         r_arready  <= (w_rd_next == R_IDLE);
         if (w_aw_hs) r_aw_idx <= s_axi.awaddr[6:2];
         if (w_w_hs) begin
            r_wdata <= s_axi.wdata;
            r_wstrb <= s_axi.wstrb;
         end
         wr_pulse <= w_commit & w_cmt_in_range;
         if (w_commit && w_cmt_in_range) wr_idx <= w_cmt_idx;
         if (w_commit) r_bresp <= w_cmt_in_range ? OKAY : SLVERR;
         // Bank read happens before this edge's write lands, so a colliding read sees the old value.
         if (w_ar_hs) begin
            r_rdata <= w_ar_in_range ? w_bank_rd : '0;
            r_rresp <= w_ar_in_range ? OKAY : SLVERR;
         end
      end
   end

   assign s_axi.awready = r_awready;
   assign s_axi.wready  = r_wready;
   assign s_axi.bvalid  = (r_wr_state == W_RESP);
   assign s_axi.bresp   = r_bresp;
   assign s_axi.arready = r_arready;
   assign s_axi.rvalid  = (r_rd_state == R_DATA);
   assign s_axi.rdata   = r_rdata;
   assign s_axi.rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_reg_slave : directed plus randomized AXI-Lite traffic against a
//                         word-array reference model of the register bank
// Revision              : 1.0
// ============================================================================
module tb_axi_lite_reg_slave;
   import axi_lite_pkg::*;

   localparam int NREG = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axi_lite bus ();

   logic [NREG*32-1:0] reg_q;
   logic               wr_pulse;
   logic [4:0]         wr_idx;

   axi_lite_reg_slave #(.NUM_REGS(NREG)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_axi    (bus),
      .reg_q    (reg_q),
      .wr_pulse (wr_pulse),
      .wr_idx   (wr_idx)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] model [NREG];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] model_flat();
      logic [511:0] f = '0;
      for (int k = 0; k < NREG; k++) f[32*k +: 32] = model[k];
      return f;
   endfunction

   function automatic logic [31:0] model_rd(input logic [6:0] a);
      int idx = int'(a[6:2]);
      return (idx < NREG) ? model[idx] : 32'h0;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NREG; k++) model[k] = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.awaddr = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
   endtask

   // Address and data presented from independent start cycles; response held for bhold cycles.
   task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_start, input int w_start, input int bhold);
      bit         aw_done = 0, w_done = 0, aw_fire, w_fire, early_chk = 0;
      int         c = 0;
      int         idx = int'(addr[6:2]);
      bit         inr = (idx < NREG);
      logic [1:0] exp_resp = inr ? 2'b00 : 2'b10;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      while (!(aw_done && w_done) && c < 30) begin
         bus.awvalid = !aw_done && (c >= aw_start);
         bus.wvalid  = !w_done && (c >= w_start);
         aw_fire = bus.awvalid && bus.awready;
         w_fire  = bus.wvalid && bus.wready;
         tick();
         c++;
         aw_done |= aw_fire;
         w_done  |= w_fire;
         if (!early_chk && (aw_done != w_done)) begin
            chk("half_ready", {bus.awready, bus.wready}, aw_done ? 2'b01 : 2'b10);
            chk("half_no_bvalid", bus.bvalid, 1'b0);
            early_chk = 1;
         end
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         chk("wr_timeout", 1'b0, 1'b1);
         return;
      end
      if (inr) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
      chk("bvalid", bus.bvalid, 1'b1);
      chk("bresp", bus.bresp, exp_resp);
      chk("wr_pulse", wr_pulse, inr);
      if (inr) chk("wr_idx", wr_idx, idx);
      chk("bank", reg_q, model_flat());
      for (int k = 0; k <= bhold; k++) begin
         bus.bready = (k == bhold);
         tick();
         if (k == 0) chk("pulse_one_cycle", wr_pulse, 1'b0);
         if (k < bhold) begin
            chk("b_hold", {bus.bvalid, bus.bresp}, {1'b1, exp_resp});
            chk("aw_w_blocked", {bus.awready, bus.wready}, 2'b00);
         end
      end
      bus.bready = 1'b0;
      chk("bvalid_clear", bus.bvalid, 1'b0);
   endtask

   task automatic axi_read(input logic [6:0] addr, input int rhold);
      int          c = 0;
      bit          inr = (int'(addr[6:2]) < NREG);
      logic [31:0] exp_d = model_rd(addr);
      logic [1:0]  exp_r = inr ? 2'b00 : 2'b10;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      while (!bus.arready && c < 30) begin
         tick();
         c++;
      end
      if (!bus.arready) begin
         bus.arvalid = 1'b0;
         chk("rd_timeout", 1'b0, 1'b1);
         return;
      end
      tick();
      bus.arvalid = 1'b0;
      chk("rvalid", bus.rvalid, 1'b1);
      chk("rdata", bus.rdata, exp_d);
      chk("rresp", bus.rresp, exp_r);
      for (int k = 0; k <= rhold; k++) begin
         bus.rready = (k == rhold);
         tick();
         if (k < rhold) begin
            chk("r_hold", {bus.rvalid, bus.rdata, bus.rresp}, {1'b1, exp_d, exp_r});
            chk("ar_blocked", bus.arready, 1'b0);
         end
      end
      bus.rready = 1'b0;
      chk("rvalid_clear", bus.rvalid, 1'b0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ctrl"}, {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_pulse}, 6'b0);
      chk({tag, "_data"}, {bus.bresp, bus.rresp, bus.rdata, wr_idx}, '0);
      chk({tag, "_bank"}, reg_q, '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] old_v, new_v;
      logic [6:0]  a;
      bus_idle();
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");

      rst_n = 1'b1;
      chk("ready_at_release", {bus.awready, bus.wready, bus.arready}, 3'b000);
      tick();
      chk("ready_after_release", {bus.awready, bus.wready, bus.arready}, 3'b111);

      // Test-plan directed cases.
      axi_write(7'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      axi_write(7'h04, 32'h12345678, 4'hF, 3, 0, 0);
      axi_write(7'h0C, 32'h11223344, 4'hF, 0, 0, 0);
      axi_write(7'h0C, 32'hAABBCCDD, 4'h5, 0, 0, 0);
      chk("strobe_merge", reg_q[3*32 +: 32], 32'h11BB33DD);
      axi_write(7'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      axi_read(7'h7C, 0);
      axi_read(7'h08, 0);
      axi_write(7'h10, 32'h0BADC0DE, 4'hF, 2, 0, 5);
      axi_read(7'h10, 4);
      axi_write(7'h14, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
      axi_write(7'h3C, 32'h5A5A5A5A, 4'hF, 0, 2, 1);

      // Read capture and write commit on the same edge to the same register.
      old_v = model[2];
      new_v = $urandom;
      bus.awaddr = 7'h08; bus.wdata = new_v; bus.wstrb = 4'hF;
      bus.araddr = 7'h08;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
      bus.bready = 1'b1; bus.rready = 1'b1;
      chk("collide_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      model[2] = new_v;
      chk("collide_rdata_old", bus.rdata, old_v);
      chk("collide_valids", {bus.bvalid, bus.rvalid}, 2'b11);
      chk("collide_bank", reg_q, model_flat());
      tick();
      bus.bready = 1'b0; bus.rready = 1'b0;
      chk("collide_clear", {bus.bvalid, bus.rvalid}, 2'b00);

      // Reset while the address half of a write is latched.
      bus.awaddr = 7'h18; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      chk("aw_only_ready", {bus.awready, bus.wready}, 2'b01);
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      chk_reset_state("async_reset");
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset_no_bvalid", bus.bvalid, 1'b0);
      axi_write(7'h18, 32'h600DF00D, 4'hF, 0, 0, 0);
      axi_read(7'h18, 1);

      // Randomized traffic.
      for (int i = 0; i < 80; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
         else
            axi_read(a, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
